// File: rtl/ahci_pkg.sv
// ahci_pkg: shared types and constants for the AHCI bus-master fetch engines.
//   fetch_state_e   - state encoding for the command-header fetch FSM
//   CMD_HDR_BYTES   - size of one command header in bytes
//   CMD_HDR_BEATS   - number of 64-bit beats per command header
//   CLB_ALIGN_MASK  - PxCLB is 1 KB aligned; low 10 bits are ignored
//   hdr_addr()      - byte address of a slot's command header
package ahci_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_DONE,
    S_DRAIN
  } fetch_state_e;

  localparam int unsigned CMD_HDR_BYTES  = 32;
  localparam int unsigned CMD_HDR_BEATS  = 4;
  localparam logic [31:0] CLB_ALIGN_MASK = 32'hFFFF_FC00;

  // Slot offset occupies bits [9:5] only, so OR-ing never carries into PxCLB.
  function automatic logic [31:0] hdr_addr(input logic [31:0] clb,
                                           input logic [4:0]  slot);
    return (clb & CLB_ALIGN_MASK) | {22'b0, slot, 5'b0};
  endfunction

endpackage

// File: rtl/ahci_watchdog.sv
// ahci_watchdog: no-progress watchdog for bus-master fetch engines.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - restart the count (progress seen or state change)
//   en       - count this cycle when not cleared
//   expire   - count has reached all-ones; holds until cleared
module ahci_watchdog #(
  parameter int unsigned W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt;

  assign expire = (cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ctba_hdr_fetch.sv
// ctba_hdr_fetch: fetches one 32-byte command header (4 x 64-bit beats) from
// PxCLB + slot*32 over a bus-master read channel and streams the beats into
// the port's command-header cache.
//   sys_clk, sys_rst            - clock, asynchronous active-high reset
//   port2ctba_FetchCmd_req/slot - level fetch request and slot number
//   port2ctba_PxCLB             - command-list base (1 KB aligned)
//   ctba2port_FetchCmd_done/err - one-cycle completion / failure pulses
//   ctba2port_do/idx/ack        - beat data, qword index, write strobe
//   mst_rd_*                    - bus-master read request / data channel
module ctba_hdr_fetch
  import ahci_pkg::*;
#(
  parameter int unsigned C_TIMEOUT_W = 16,
  parameter int unsigned C_BEATS     = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        port2ctba_FetchCmd_req,
  input  logic [4:0]  port2ctba_FetchCmd_slot,
  input  logic [31:0] port2ctba_PxCLB,
  output logic        ctba2port_FetchCmd_done,
  output logic        ctba2port_FetchCmd_err,
  output logic [63:0] ctba2port_do,
  output logic [1:0]  ctba2port_idx,
  output logic        ctba2port_ack,
  output logic        mst_rd_req,
  output logic [31:0] mst_rd_addr,
  output logic [2:0]  mst_rd_len,
  input  logic        mst_rd_gnt,
  input  logic [63:0] mst_rd_data,
  input  logic        mst_rd_valid,
  input  logic        mst_rd_err
);

  localparam logic [1:0] LAST_BEAT = 2'(C_BEATS - 1);

  fetch_state_e state, state_d;
  logic [1:0]   beat_cnt, beat_cnt_d;
  logic         done_pend, done_pend_d;
  logic [63:0]  do_d;
  logic [1:0]   idx_d;
  logic         ack_d, err_d, req_d;
  logic [31:0]  addr_d;
  logic         wd_clr, wd_en, wd_expire;

  assign mst_rd_len = 3'(CMD_HDR_BEATS);

  assign wd_en  = (state == S_REQ) || (state == S_DATA) || (state == S_DRAIN);
  assign wd_clr = (state_d != state) || mst_rd_gnt || mst_rd_valid;

  ahci_watchdog #(.W(C_TIMEOUT_W)) u_watchdog (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state                   <= S_IDLE;
      beat_cnt                <= '0;
      done_pend               <= 1'b0;
      ctba2port_do            <= '0;
      ctba2port_idx           <= '0;
      ctba2port_ack           <= 1'b0;
      ctba2port_FetchCmd_done <= 1'b0;
      ctba2port_FetchCmd_err  <= 1'b0;
      mst_rd_req              <= 1'b0;
      mst_rd_addr             <= '0;
    end else begin
      state                   <= state_d;
      beat_cnt                <= beat_cnt_d;
      done_pend               <= done_pend_d;
      ctba2port_do            <= do_d;
      ctba2port_idx           <= idx_d;
      ctba2port_ack           <= ack_d;
      ctba2port_FetchCmd_done <= done_pend;
      ctba2port_FetchCmd_err  <= err_d;
      mst_rd_req              <= req_d;
      mst_rd_addr             <= addr_d;
    end
  end

  always_comb begin
    state_d     = state;
    beat_cnt_d  = beat_cnt;
    done_pend_d = 1'b0;
    do_d        = ctba2port_do;
    idx_d       = ctba2port_idx;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    req_d       = mst_rd_req;
    addr_d      = mst_rd_addr;

    unique case (state)
      S_IDLE: begin
        if (port2ctba_FetchCmd_req) begin
          addr_d  = hdr_addr(port2ctba_PxCLB, port2ctba_FetchCmd_slot);
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (mst_rd_err) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (mst_rd_gnt) begin
          // A grant racing the port's abort still owes us 4 beats.
          req_d      = 1'b0;
          beat_cnt_d = '0;
          state_d    = port2ctba_FetchCmd_req ? S_DATA : S_DRAIN;
        end else if (!port2ctba_FetchCmd_req) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (wd_expire) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DATA: begin
        if (mst_rd_err) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!port2ctba_FetchCmd_req) begin
          // Abort: a beat arriving on the abort cycle is drained silently.
          state_d = S_DRAIN;
          if (mst_rd_valid) begin
            beat_cnt_d = beat_cnt + 2'd1;
            if (beat_cnt == LAST_BEAT) state_d = S_IDLE;
          end
        end else if (mst_rd_valid) begin
          do_d       = mst_rd_data;
          idx_d      = beat_cnt;
          ack_d      = 1'b1;
          beat_cnt_d = beat_cnt + 2'd1;
          if (beat_cnt == LAST_BEAT) begin
            done_pend_d = 1'b1;
            state_d     = S_DONE;
          end
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DRAIN: begin
        if (mst_rd_err || wd_expire) begin
          state_d = S_IDLE;
        end else if (mst_rd_valid) begin
          beat_cnt_d = beat_cnt + 2'd1;
          if (beat_cnt == LAST_BEAT) state_d = S_IDLE;
        end
      end

      S_DONE: begin
        if (!port2ctba_FetchCmd_req) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctba_hdr_fetch.sv
// tb_ctba_hdr_fetch: randomized self-checking bench for ctba_hdr_fetch with a
// transaction-level model of the expected acks, done/err pulses and address.
module tb_ctba_hdr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [4:0]  slot;
  logic [31:0] clb;
  logic        done, err, ack;
  logic [63:0] dout;
  logic [1:0]  idx;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [2:0]  rd_len;
  logic        gnt, valid, rd_err;
  logic [63:0] rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned cyc = 0;
  int unsigned done_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  int unsigned last_ack_cyc = 0, done_cyc = 0, err_cyc = 0, req_rise_cyc = 0;
  logic        rd_req_prev = 1'b0;
  logic [65:0] ack_q[$];   // {idx, data}

  ctba_hdr_fetch #(.C_TIMEOUT_W(4), .C_BEATS(4)) dut (
    .sys_clk                 (clk),
    .sys_rst                 (rst),
    .port2ctba_FetchCmd_req  (req),
    .port2ctba_FetchCmd_slot (slot),
    .port2ctba_PxCLB         (clb),
    .ctba2port_FetchCmd_done (done),
    .ctba2port_FetchCmd_err  (err),
    .ctba2port_do            (dout),
    .ctba2port_idx           (idx),
    .ctba2port_ack           (ack),
    .mst_rd_req              (rd_req),
    .mst_rd_addr             (rd_addr),
    .mst_rd_len              (rd_len),
    .mst_rd_gnt              (gnt),
    .mst_rd_data             (rdata),
    .mst_rd_valid            (valid),
    .mst_rd_err              (rd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ack) begin
      ack_q.push_back({idx, dout});
      last_ack_cyc = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err)  begin err_cnt++;  err_cyc  = cyc; end
    if ((done && err) || (done && ack)) overlap_cnt++;
    if (rd_req && !rd_req_prev) req_rise_cyc = cyc;
    rd_req_prev = rd_req;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] b, input logic [4:0] s);
    return (b / 32'd1024) * 32'd1024 + 32'(s) * 32'd32;
  endfunction

  task automatic start_fetch(input logic [31:0] b, input logic [4:0] s);
    clb  = b;
    slot = s;
    req  = 1'b1;
    for (int i = 0; i < 5 && !rd_req; i++) step(1);
    check("rd_req_up", rd_req, 1'b1);
    check("rd_addr", rd_addr, model_addr(b, s));
  endtask

  task automatic grant(input int unsigned dly);
    step(dly);
    gnt = 1'b1;
    step(1);
    gnt = 1'b0;
    check("rd_req_after_gnt", rd_req, 1'b0);
  endtask

  task automatic beat(input logic [63:0] d, input int unsigned gap);
    step(gap);
    valid = 1'b1;
    rdata = d;
    step(1);
    valid = 1'b0;
  endtask

  task automatic wait_end(input int unsigned d0, input int unsigned e0);
    for (int i = 0; i < 12 && done_cnt == d0 && err_cnt == e0; i++) step(1);
    step(3);
  endtask

  task automatic check_acks(input string tag, input logic [63:0] d[4], input int unsigned n);
    check({tag, "_nacks"}, ack_q.size(), n);
    for (int i = 0; i < int'(n) && i < ack_q.size(); i++) begin
      check({tag, "_idx"},  ack_q[i][65:64], i);
      check({tag, "_data"}, ack_q[i][63:0], d[i]);
    end
  endtask

  task automatic run_normal(input logic [31:0] b, input logic [4:0] s,
                            input int unsigned gdly, input int unsigned gap_max);
    logic [63:0] d[4];
    int unsigned d0 = done_cnt, e0 = err_cnt;
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    ack_q.delete();
    start_fetch(b, s);
    grant(gdly);
    for (int i = 0; i < 4; i++) beat(d[i], $urandom_range(gap_max, 0));
    wait_end(d0, e0);
    check_acks("norm", d, 4);
    check("norm_done", done_cnt - d0, 1);
    check("norm_err", err_cnt - e0, 0);
    check("norm_done_lat", done_cyc - last_ack_cyc, 1);
    req = 1'b0;
    step(2);
  endtask

  task automatic run_error(input int unsigned k, input logic with_valid);
    logic [63:0] d[4];
    int unsigned d0 = done_cnt, e0 = err_cnt;
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    ack_q.delete();
    start_fetch($urandom, 5'($urandom));
    grant($urandom_range(3, 0));
    for (int i = 0; i < int'(k); i++) beat(d[i], 0);
    valid  = with_valid;
    rdata  = d[k];
    rd_err = 1'b1;
    step(1);
    valid  = 1'b0;
    rd_err = 1'b0;
    wait_end(d0, e0);
    check_acks("berr", d, k);
    check("berr_err", err_cnt - e0, 1);
    check("berr_done", done_cnt - d0, 0);
    req = 1'b0;
    step(2);
  endtask

  task automatic run_drain(input int unsigned k);
    logic [63:0] d[4];
    int unsigned d0 = done_cnt, e0 = err_cnt;
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    ack_q.delete();
    start_fetch($urandom, 5'($urandom));
    grant(1);
    for (int i = 0; i < int'(k); i++) beat(d[i], 0);
    req = 1'b0;
    for (int i = int'(k); i < 4; i++) beat(d[i], $urandom_range(3, 0));
    step(4);
    check_acks("drain", d, k);
    check("drain_done", done_cnt - d0, 0);
    check("drain_err", err_cnt - e0, 0);
  endtask

  task automatic run_abort();
    int unsigned d0 = done_cnt, e0 = err_cnt;
    ack_q.delete();
    start_fetch($urandom, 5'($urandom));
    step($urandom_range(2, 0));
    req = 1'b0;
    step(3);
    check("abort_rd_req", rd_req, 1'b0);
    check("abort_done", done_cnt - d0, 0);
    check("abort_err", err_cnt - e0, 0);
    check("abort_nacks", ack_q.size(), 0);
  endtask

  initial begin
    int unsigned d0, e0, lat;
    rst = 1'b1; req = 1'b0; slot = '0; clb = '0;
    gnt = 1'b0; valid = 1'b0; rd_err = 1'b0; rdata = '0;
    step(3);
    check("rst_ack", ack, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_do", dout, 64'd0);
    check("rst_idx", idx, 2'd0);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_rd_addr", rd_addr, 32'd0);
    check("rd_len", rd_len, 3'd4);
    rst = 1'b0;
    step(2);

    // Directed case from the header address example.
    run_normal(32'h1234_5400, 5'd5, 2, 0);
    check("dir_addr", model_addr(32'h1234_5400, 5'd5), 32'h1234_54A0);
    check("dir_addr_dut", rd_addr, 32'h1234_54A0);

    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(3, 0))
        0: run_normal($urandom, 5'($urandom), $urandom_range(4, 0), 4);
        1: begin
             run_error($urandom_range(3, 0), 1'($urandom));
             run_normal($urandom, 5'($urandom), 1, 2);
           end
        2: begin
             run_drain($urandom_range(3, 1));
             run_normal($urandom, 5'($urandom), 0, 1);
           end
        default: begin
             run_abort();
             run_normal($urandom, 5'($urandom), 2, 3);
           end
      endcase
    end

    // Watchdog with a 4-bit counter: grant never arrives.
    d0 = done_cnt; e0 = err_cnt;
    ack_q.delete();
    start_fetch(32'hABCD_0000, 5'd31);
    for (int i = 0; i < 40 && err_cnt == e0; i++) step(1);
    step(2);
    check("to_err", err_cnt - e0, 1);
    check("to_done", done_cnt - d0, 0);
    check("to_rd_req", rd_req, 1'b0);
    check("to_nacks", ack_q.size(), 0);
    // 15 idle cycles to reach all-ones, then the registered err.
    lat = err_cyc - req_rise_cyc;
    check("to_latency_ok", (lat >= 15 && lat <= 17), 1'b1);
    req = 1'b0;
    step(2);

    // Asynchronous reset in the middle of the data phase.
    d0 = done_cnt; e0 = err_cnt;
    start_fetch($urandom, 5'($urandom));
    grant(1);
    beat({$urandom, $urandom}, 0);
    valid = 1'b1;
    rdata = {$urandom, $urandom};
    step(1);
    #2 rst = 1'b1;
    #1;
    check("arst_ack", ack, 1'b0);
    check("arst_do", dout, 64'd0);
    check("arst_idx", idx, 2'd0);
    check("arst_rd_req", rd_req, 1'b0);
    check("arst_rd_addr", rd_addr, 32'd0);
    check("arst_done", done, 1'b0);
    check("arst_err", err, 1'b0);
    valid = 1'b0;
    req   = 1'b0;
    #3 rst = 1'b0;
    step(6);
    check("arst_post_done", done_cnt - d0, 0);
    check("arst_post_err", err_cnt - e0, 0);
    run_normal($urandom, 5'($urandom), 1, 2);

    check("no_overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
